// File: rtl/ctech_lib_clk_sel_pkg.sv
// Shared types and limits for the break-before-make clock-OR select sequencer.
package ctech_lib_clk_sel_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ARM   = 2'd1,
        ON    = 2'd2,
        DRAIN = 2'd3
    } sel_state_e;

    localparam int unsigned DEAD_CYC_MAX = 15;

    // Smallest counter width able to hold DEAD_CYC-1 with 2**w > dead_cyc.
    function automatic int unsigned cnt_w_min(input int unsigned dead_cyc);
        return (dead_cyc < 2) ? 1 : $clog2(dead_cyc + 1);
    endfunction

    localparam int unsigned CNT_W_DEF = cnt_w_min(DEAD_CYC_MAX);

endpackage

// File: rtl/ctech_lib_clk_or_sel_ctl_if.sv
// Run/select handshake and branch-enable bundle between requester and sequencer.
interface ctech_lib_clk_or_sel_ctl_if;

    logic run;
    logic sel_vld;
    logic sel_req;
    logic sel_ack;
    logic en0;
    logic en1;
    logic cur_sel;
    logic busy;

    modport master (
        output run, sel_vld, sel_req,
        input  sel_ack, en0, en1, cur_sel, busy
    );

    modport slave (
        input  run, sel_vld, sel_req,
        output sel_ack, en0, en1, cur_sel, busy
    );

endinterface

// File: rtl/ctech_lib_clk_sel_dcnt.sv
// Loadable down-counter with zero flag; times the all-off arming window.
module ctech_lib_clk_sel_dcnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/ctech_lib_clk_or_sel_ctl.sv
// Break-before-make enable sequencer for two gated clocks feeding a clock-OR cell.
// Optional DFT bypass (forces branch 0) when CTECH_LIB_CLK_OR_SEL_DFT_BYPASS_EN is defined.
module ctech_lib_clk_or_sel_ctl
    import ctech_lib_clk_sel_pkg::*;
#(
    parameter int unsigned DEAD_CYC = 2,
    parameter bit          RST_SEL  = 1'b0,
    parameter int unsigned CNT_W    = 4
) (
    input  logic clk,
    input  logic rst_b,
`ifdef CTECH_LIB_CLK_OR_SEL_DFT_BYPASS_EN
    input  logic dft_byp,
`endif
    ctech_lib_clk_or_sel_ctl_if.slave sel_if
);

    sel_state_e state_q, state_d;
    logic       tgt_q, tgt_d;
    logic       cur_sel_q, cur_sel_d;
    logic       ack_q, ack_d;
    logic       en0_q, en0_d;
    logic       en1_q, en1_d;
    logic       busy_q, busy_d;
    logic       cnt_load, cnt_dec, cnt_zero_c;

    ctech_lib_clk_sel_dcnt #(.CNT_W(CNT_W)) u_dcnt (
        .clk      (clk),
        .rst_b    (rst_b),
        .load     (cnt_load),
        .load_val (CNT_W'(DEAD_CYC - 1)),
        .dec      (cnt_dec),
        .zero_c   (cnt_zero_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= OFF;
            tgt_q     <= RST_SEL;
            cur_sel_q <= RST_SEL;
            ack_q     <= 1'b0;
            en0_q     <= 1'b0;
            en1_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            cur_sel_q <= cur_sel_d;
            ack_q     <= ack_d;
            en0_q     <= en0_d;
            en1_q     <= en1_d;
            busy_q    <= busy_d;
        end
    end

    // Next state; run falling always takes priority over a pending select.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        cur_sel_d = cur_sel_q;
        ack_d     = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state_q)
            OFF: begin
                if (sel_if.run) begin
                    state_d  = ARM;
                    cnt_load = 1'b1;
                end
            end
            ARM: begin
                if (!sel_if.run) begin
                    state_d = OFF;
                end else if (cnt_zero_c) begin
                    state_d   = ON;
                    cur_sel_d = tgt_q;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ON: begin
                if (!sel_if.run) begin
                    state_d = DRAIN;
                end else if (sel_if.sel_vld) begin
                    ack_d = 1'b1;
                    if (sel_if.sel_req != cur_sel_q) begin
                        tgt_d   = sel_if.sel_req;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (sel_if.run) begin
                    state_d  = ARM;
                    cnt_load = 1'b1;
                end else begin
                    state_d = OFF;
                end
            end
            default: state_d = OFF;
        endcase
        en0_d  = (state_d == ON) && !cur_sel_d;
        en1_d  = (state_d == ON) &&  cur_sel_d;
        busy_d = (state_d == ARM) || (state_d == DRAIN);
    end

`ifdef CTECH_LIB_CLK_OR_SEL_DFT_BYPASS_EN
    // Bypass pins branch 0 on while the sequencer keeps tracking underneath.
    assign sel_if.en0     = dft_byp | en0_q;
    assign sel_if.en1     = ~dft_byp & en1_q;
    assign sel_if.cur_sel = ~dft_byp & cur_sel_q;
    assign sel_if.busy    = ~dft_byp & busy_q;
    assign sel_if.sel_ack = ~dft_byp & ack_q;
`else
    assign sel_if.en0     = en0_q;
    assign sel_if.en1     = en1_q;
    assign sel_if.cur_sel = cur_sel_q;
    assign sel_if.busy    = busy_q;
    assign sel_if.sel_ack = ack_q;
`endif

endmodule

// File: tb/tb_ctech_lib_clk_or_sel_ctl.sv
// Self-checking bench for ctech_lib_clk_or_sel_ctl (DEAD_CYC=2, RST_SEL=0).
module tb_ctech_lib_clk_or_sel_ctl;

    localparam int unsigned DEAD = 2;

    logic clk     = 1'b0;
    logic rst_b   = 1'b0;
    logic dft_byp = 1'b0;

    int checks   = 0;
    int failures = 0;

    ctech_lib_clk_or_sel_ctl_if sel_if ();

    ctech_lib_clk_or_sel_ctl #(
        .DEAD_CYC (DEAD),
        .RST_SEL  (1'b0),
        .CNT_W    (4)
    ) dut (
        .clk     (clk),
        .rst_b   (rst_b),
`ifdef CTECH_LIB_CLK_OR_SEL_DFT_BYPASS_EN
        .dft_byp (dft_byp),
`endif
        .sel_if  (sel_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: clock owned / draining / arming with N dead cycles left / idle.
    logic m_running  = 1'b0;
    logic m_drain    = 1'b0;
    int   m_arm_left = 0;
    logic m_cur      = 1'b0;
    logic m_tgt      = 1'b0;
    logic m_ack      = 1'b0;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_running = 1'b0; m_drain = 1'b0; m_arm_left = 0;
            m_cur = 1'b0; m_tgt = 1'b0; m_ack = 1'b0;
        end else begin
            m_ack = 1'b0;
            if (m_running) begin
                if (!sel_if.run) begin
                    m_running = 1'b0; m_drain = 1'b1;
                end else if (sel_if.sel_vld) begin
                    m_ack = 1'b1;
                    if (sel_if.sel_req != m_cur) begin
                        m_tgt = sel_if.sel_req; m_running = 1'b0; m_drain = 1'b1;
                    end
                end
            end else if (m_drain) begin
                m_drain = 1'b0;
                if (sel_if.run) m_arm_left = DEAD;
            end else if (m_arm_left > 0) begin
                if (!sel_if.run) begin
                    m_arm_left = 0;
                end else begin
                    m_arm_left--;
                    if (m_arm_left == 0) begin
                        m_running = 1'b1; m_cur = m_tgt;
                    end
                end
            end else if (sel_if.run) begin
                m_arm_left = DEAD;
            end
        end
    end

    // Every-cycle comparison against the reference, away from the active edge.
    always @(negedge clk) begin
        logic e0, e1, ec, eb, ea;
        e0 = m_running && !m_cur;
        e1 = m_running &&  m_cur;
        ec = m_cur;
        eb = m_drain || (m_arm_left > 0);
        ea = m_ack;
        if (dft_byp) begin
            e0 = 1'b1; e1 = 1'b0; ec = 1'b0; eb = 1'b0; ea = 1'b0;
        end
        chk("model_en0", 32'(sel_if.en0), 32'(e0));
        chk("model_en1", 32'(sel_if.en1), 32'(e1));
        chk("model_cur_sel", 32'(sel_if.cur_sel), 32'(ec));
        chk("model_busy", 32'(sel_if.busy), 32'(eb));
        chk("model_sel_ack", 32'(sel_if.sel_ack), 32'(ea));
        chk("en_exclusive", 32'(sel_if.en0 & sel_if.en1), 32'd0);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic e0, input logic e1, input logic cs,
                       input logic bz, input logic ak);
        chk({nm, "_en0"}, 32'(sel_if.en0), 32'(e0));
        chk({nm, "_en1"}, 32'(sel_if.en1), 32'(e1));
        chk({nm, "_cur_sel"}, 32'(sel_if.cur_sel), 32'(cs));
        chk({nm, "_busy"}, 32'(sel_if.busy), 32'(bz));
        chk({nm, "_ack"}, 32'(sel_if.sel_ack), 32'(ak));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        sel_if.run = 1'b0; sel_if.sel_vld = 1'b0; sel_if.sel_req = 1'b0;
        cyc(3);
        lit("reset", 0, 0, 0, 0, 0);

        // 1: release reset with run high; en0 in cycle DEAD+1.
        rst_b = 1'b1; sel_if.run = 1'b1;
        cyc(1); lit("arm_c1", 0, 0, 0, 1, 0);
        cyc(1); lit("arm_c2", 0, 0, 0, 1, 0);
        cyc(1); lit("on_c3", 1, 0, 0, 0, 0);

        // 2: switch 0 -> 1.
        sel_if.sel_vld = 1'b1; sel_if.sel_req = 1'b1;
        cyc(1); lit("sw1_ack", 0, 0, 0, 1, 1);
        sel_if.sel_vld = 1'b0;
        cyc(2); lit("sw1_gap", 0, 0, 0, 1, 0);
        cyc(1); lit("sw1_on", 0, 1, 1, 0, 0);

        // 3: same-branch request acks without a gap.
        sel_if.sel_vld = 1'b1; sel_if.sel_req = 1'b1;
        cyc(1); lit("same_ack", 0, 1, 1, 0, 1);
        sel_if.sel_vld = 1'b0;
        cyc(1); lit("same_hold", 0, 1, 1, 0, 0);

        // 4: run falls with a switch request; request held through OFF.
        sel_if.run = 1'b0; sel_if.sel_vld = 1'b1; sel_if.sel_req = 1'b0;
        cyc(1); lit("runfall_drain", 0, 0, 1, 1, 0);
        cyc(1); lit("runfall_off", 0, 0, 1, 0, 0);
        cyc(2); lit("off_noack", 0, 0, 1, 0, 0);
        sel_if.run = 1'b1;
        cyc(3); lit("rearm_on", 0, 1, 1, 0, 0);
        cyc(1); lit("held_ack", 0, 0, 1, 1, 1);
        sel_if.sel_vld = 1'b0;
        cyc(3); lit("second_drain_on", 1, 0, 0, 0, 0);

        // ARM abort keeps enables low, then re-arm.
        sel_if.run = 1'b0;
        cyc(2); lit("stop_off", 0, 0, 0, 0, 0);
        sel_if.run = 1'b1;
        cyc(1); lit("abort_arm", 0, 0, 0, 1, 0);
        sel_if.run = 1'b0;
        cyc(1); lit("abort_off", 0, 0, 0, 0, 0);
        sel_if.run = 1'b1;
        cyc(3); lit("abort_rearm", 1, 0, 0, 0, 0);

        // 5: reset while arming toward branch 0 from branch 1.
        sel_if.sel_vld = 1'b1; sel_if.sel_req = 1'b1;
        cyc(1); sel_if.sel_vld = 1'b0;
        cyc(3); lit("pre_rst_on1", 0, 1, 1, 0, 0);
        sel_if.sel_vld = 1'b1; sel_if.sel_req = 1'b0;
        cyc(1); sel_if.sel_vld = 1'b0;
        cyc(1); lit("pre_rst_arm", 0, 0, 1, 1, 0);
        #2; rst_b = 1'b0; sel_if.run = 1'b0;
        #1; lit("async_rst", 0, 0, 0, 0, 0);
        cyc(2); rst_b = 1'b1;
        cyc(3); lit("post_rst", 0, 0, 0, 0, 0);
        sel_if.run = 1'b1;
        cyc(3); lit("post_rst_on", 1, 0, 0, 0, 0);

`ifdef CTECH_LIB_CLK_OR_SEL_DFT_BYPASS_EN
        // 6: bypass across a switch to branch 1.
        dft_byp = 1'b1; sel_if.sel_vld = 1'b1; sel_if.sel_req = 1'b1;
        cyc(1); lit("byp_ack", 1, 0, 0, 0, 0);
        sel_if.sel_vld = 1'b0;
        cyc(3); lit("byp_hold", 1, 0, 0, 0, 0);
        dft_byp = 1'b0;
        #1; lit("byp_release", 0, 1, 1, 0, 0);
`endif

        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctech_lib_clk_or_sel_ctl.md
Name: ctech_lib_clk_or_sel_ctl

Overview:
- Break-before-make enable sequencer for two clock-gate branches whose gated outputs are merged by the clock-OR cell downstream.
- Guarantees that at most one branch enable is high in any cycle.
- Inserts DEAD_CYC all-off cycles on every source change, so the merged clock never sees overlapping or runt pulses.
- Runs on the single free-running clock that both branch gates derive from.

Parameters:
- DEAD_CYC, 2: all-off cycles inserted between deasserting one enable and asserting the other; legal range 1..15.
- RST_SEL, 0: branch selected when run first rises after reset.
- CNT_W, 4: dead-cycle counter width; must satisfy 2**CNT_W > DEAD_CYC.

Ports:
- clk  in  1: free-running source clock.
- rst_b  in  1: asynchronous active-low reset.
- run  in  1: global enable; 0 drives both branches off after a drain.
- sel_vld  in  1: switch request valid.
- sel_req  in  1: requested branch (0 or 1).
- sel_ack  out  1: one-cycle pulse when the request is accepted.
- en0  out  1: gate enable, branch 0.
- en1  out  1: gate enable, branch 1.
- cur_sel  out  1: branch currently owning the clock; holds its last value while OFF or draining.
- busy  out  1: high in DRAIN and ARM.

Behaviour:
- Reset (rst_b=0, asynchronous): state OFF; en0=en1=0; sel_ack=0; busy=0; cur_sel=RST_SEL; counter=0; pending target=RST_SEL. All outputs are registered.
- State OFF:
  - en0=en1=0.
  - run=1 -> ARM toward the pending target.
- State ARM:
  - Counter loads DEAD_CYC-1 on entry and decrements each cycle.
  - At count 0 -> ON. The target enable rises in the first ON cycle, and cur_sel updates to the target in the same cycle.
  - Minimum latency from run rise to en high is DEAD_CYC+1 cycles.
- State ON:
  - Exactly one enable is high, matching cur_sel.
  - sel_vld=1 with sel_req==cur_sel: sel_ack pulses the next cycle; no other change.
  - sel_vld=1 with sel_req!=cur_sel: sel_ack pulses the next cycle; pending target := sel_req; the active enable drops in that same next cycle; go to DRAIN.
  - run=0: the active enable drops next cycle; go to DRAIN with target unchanged.
- State DRAIN: one cycle with both enables low. Then:
  - run=1 -> ARM.
  - run=0 -> OFF.
- Total off-time on a switch is DEAD_CYC+1 cycles, measured from the old enable falling to the new enable rising.
- sel_vld outside ON:
  - No ack while OFF, DRAIN or ARM.
  - The requester holds sel_vld until sel_ack.
  - A held request is evaluated when ON is reached. If it matches the new cur_sel it acks immediately; otherwise a second drain follows.
- Simultaneous run fall and sel_vld in ON: run wins. No ack; the request stays pending.
- run toggling during ARM: run=0 aborts to OFF with enables still low; the target is kept.
- Invariant: en0 & en1 == 0 in every cycle, including the reset release cycle.
- Reset asserted mid-switch: enables drop asynchronously; the pending request is lost.

Optional Feature:
- Macro: CTECH_LIB_CLK_OR_SEL_DFT_BYPASS_EN.
- Defined:
  - Adds input port dft_byp (1 bit).
  - dft_byp=1 forces en0=1, en1=0, cur_sel=0, busy=0 combinationally, overriding the FSM outputs.
  - The FSM keeps running underneath; sel_ack stays 0 while bypassed.
- Undefined: port absent; behaviour exactly as above.

Decomposition:
- Package ctech_lib_clk_sel_pkg holds:
  - state enum: OFF, ARM, ON, DRAIN (2 bits);
  - DEAD_CYC_MAX=15;
  - localparam helper for CNT_W.
- One sub-module: ctech_lib_clk_sel_dcnt, a loadable down-counter with a zero flag used by ARM.

Test Plan:
1. Reset release, run=1 at cycle 0, DEAD_CYC=2, RST_SEL=0 -> en0 rises at cycle 3; en1 stays 0; cur_sel=0.
2. In ON with sel=0, pulse sel_vld=1, sel_req=1 -> sel_ack next cycle and en0 falls that cycle; en1 rises 3 cycles later; never both high.
3. sel_vld=1, sel_req=cur_sel=1 -> sel_ack one cycle later; en1 stays high with no gap.
4. run falls in the same cycle as sel_vld with sel_req!=cur_sel -> no ack; enables go low and the FSM goes DRAIN->OFF. Run rises again -> ON, then ack, then a second drain to the new branch.
5. rst_b asserted while busy=1 (ARM) -> en0=en1=0 immediately; after release, cur_sel=RST_SEL and there is no stale ack.
6. Macro defined, dft_byp=1 during a switch -> en0=1, en1=0 held. Release -> outputs return to the FSM state with the en0&en1 invariant intact.
